// File: rtl/topk_pkg.sv
// Shared types and sizing helpers for the top-K stream reader.
// Holds the controller state encoding and the rank/count width rules.
package topk_pkg;

    localparam int unsigned DEFAULT_K = 4;

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_e;

    // Width of a rank index 0..k-1; never narrower than one bit.
    function automatic int unsigned rank_width(input int unsigned k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    // Width needed to hold a count of 0..k entries.
    function automatic int unsigned count_width(input int unsigned k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/topk_slot.sv
// One rank cell of the sorted table: holds a value plus valid bit and flags
// whether an incoming sample belongs at or above this rank.
module topk_slot #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] above_val_i,
    input  logic                  above_vld_i,
    output logic [DATA_WIDTH-1:0] val_o,
    output logic                  vld_o,
    output logic                  ge_o
);

    logic [DATA_WIDTH-1:0] val_q;
    logic                  vld_q;

    // An empty cell always takes the sample; ties insert above the stored copy.
    assign ge_o  = !vld_q || (data_i >= val_q);
    assign val_o = val_q;
    assign vld_o = vld_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            val_q <= '0;
            vld_q <= 1'b0;
        end else if (clear_i) begin
            vld_q <= 1'b0;
        end else if (shift_i) begin
            val_q <= above_val_i;
            vld_q <= above_vld_i;
        end else if (load_i) begin
            val_q <= data_i;
            vld_q <= 1'b1;
        end
    end

endmodule

// File: rtl/topk_stream_reader.sv
// Keeps the K largest unsigned samples seen since the last clear, sorted
// descending, and reads the ranked table out as a valid/ready burst.
module topk_stream_reader
    import topk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned K          = DEFAULT_K,
    localparam int unsigned RW        = rank_width(K),
    localparam int unsigned CW        = count_width(K)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  clear,
    input  logic                  dump_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RW-1:0]         out_rank,
    output logic                  out_last,
    output logic [CW-1:0]         count,
    output logic                  busy
);

    state_e                state_q;
    logic [RW-1:0]         rank_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;

    logic [DATA_WIDTH-1:0] top_val [K];
    logic [K-1:0]          top_vld;
    logic [K-1:0]          ge;
    logic [K-1:0]          ge_above;
    logic                  accept;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready && !clear;

    // ge is monotonic over the sorted table, so the first set bit is the
    // insertion slot; everything below it shifts down one rank.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        ge_above = '0;
        for (int unsigned i = 0; i < K; i++) begin
            ge_above[i] = acc;
            acc         = acc | ge[i];
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_slot
        logic [DATA_WIDTH-1:0] above_val;
        logic                  above_vld;

        if (i == 0) begin : g_head
            assign above_val = '0;
            assign above_vld = 1'b0;
        end else begin : g_body
            assign above_val = top_val[i-1];
            assign above_vld = top_vld[i-1];
        end

        topk_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk        (clk),
            .resetn     (resetn),
            .clear_i    (clear),
            .load_i     (accept && ge[i] && !ge_above[i]),
            .shift_i    (accept && ge_above[i]),
            .data_i     (in_data),
            .above_val_i(above_val),
            .above_vld_i(above_vld),
            .val_o      (top_val[i]),
            .vld_o      (top_vld[i]),
            .ge_o       (ge[i])
        );
    end

    // A full table still takes a qualifying sample but the count saturates.
    always_comb begin
        count_d = count_q;
        if (accept && (|ge) && (count_q != CW'(K))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            rank_q  <= '0;
            count_q <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            rank_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            case (state_q)
                IDLE: begin
                    if (dump_req && (count_d != '0)) begin
                        state_q <= DUMP;
                        rank_q  <= '0;
                    end
                end
                DUMP: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state_q <= IDLE;
                            rank_q  <= '0;
                        end else begin
                            rank_q <= rank_q + RW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == DUMP);
    assign out_valid = busy;
    assign out_rank  = busy ? rank_q : '0;
    assign out_data  = (busy && top_vld[rank_q]) ? top_val[rank_q] : '0;
    assign out_last  = busy && (CW'(rank_q) == (count_q - CW'(1)));
    assign count     = count_q;

endmodule

// File: tb/tb_topk_stream_reader.sv
// Self-checking bench for topk_stream_reader: directed scenarios plus random
// sample/dump rounds compared against a sorted-queue reference model.
module tb_topk_stream_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned K  = 4;

    logic          clk       = 1'b0;
    logic          resetn    = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          clear     = 1'b0;
    logic          dump_req  = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_rank;
    logic          out_last;
    logic [2:0]    count;
    logic          busy;

    int unsigned   n_chk  = 0;
    int unsigned   n_pass = 0;

    // Reference: the K largest samples since the last clear, largest first.
    logic [DW-1:0] mq [$];

    topk_stream_reader #(
        .DATA_WIDTH(DW),
        .K         (K)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .clear    (clear),
        .dump_req (dump_req),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_rank (out_rank),
        .out_last (out_last),
        .count    (count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [DW-1:0] x);
        mq.push_back(x);
        mq.rsort();
        if (mq.size() > K) mq.delete(mq.size() - 1);
    endtask

    task automatic clear_tbl();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mq.delete();
        check("clear_count", 32'(count), 0);
    endtask

    task automatic send(input logic [DW-1:0] x);
        check("send_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = x;
        tick();
        in_valid = 1'b0;
        model_push(x);
        check("send_count", 32'(count), mq.size());
    endtask

    // mode 0: always ready; 1: random stalls; 2: 3-cycle stall after rank 0.
    task automatic burst(input int mode);
        int r      = 0;
        int stalls = 0;
        int guard  = 0;
        int n      = mq.size();
        while (r < n && guard < 100) begin
            guard++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (stalls >= 6) || ($urandom_range(0, 2) != 0);
                default: out_ready = !(r == 1 && stalls < 3);
            endcase
            check("beat_valid", 32'(out_valid), 1);
            check("beat_data", out_data, mq[r]);
            check("beat_rank", 32'(out_rank), r);
            check("beat_last", 32'(out_last), (r == n - 1) ? 1 : 0);
            check("beat_in_ready", 32'(in_ready), 0);
            check("beat_busy", 32'(busy), 1);
            check("beat_count", 32'(count), n);
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = $urandom;
            tick();
            if (out_ready) r++;
            else stalls++;
        end
        if (guard >= 100) check("burst_timeout", 0, 1);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("end_valid", 32'(out_valid), 0);
        check("end_busy", 32'(busy), 0);
        check("end_data", out_data, 0);
        check("end_in_ready", 32'(in_ready), 1);
        check("end_count", 32'(count), n);
    endtask

    task automatic dump(input bit with_sample, input logic [DW-1:0] x, input int mode);
        dump_req = 1'b1;
        if (with_sample) begin
            in_valid = 1'b1;
            in_data  = x;
        end
        tick();
        dump_req = 1'b0;
        in_valid = 1'b0;
        if (with_sample) model_push(x);
        if (mq.size() == 0) begin
            check("empty_no_valid", 32'(out_valid), 0);
            check("empty_no_busy", 32'(busy), 0);
            tick();
            check("empty_no_valid2", 32'(out_valid), 0);
        end else begin
            burst(mode);
        end
    endtask

    initial begin
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_rank", 32'(out_rank), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        resetn = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 1);

        // Scenario 1: overflowing table, full-speed dump.
        send(5); send(9); send(3); send(7); send(1);
        check("t1_count", 32'(count), 4);
        check("t1_model_top", mq[0], 9);
        dump(1'b0, '0, 0);

        // Scenario 2: duplicates occupy separate ranks.
        clear_tbl();
        send(8); send(8); send(2);
        dump(1'b0, '0, 0);

        // Scenario 3: downstream stall freezes the beat and the table.
        clear_tbl();
        send(9); send(7); send(5); send(3);
        dump(1'b0, '0, 2);

        // Scenario 4: clear aborts a burst on the rank-1 beat.
        clear_tbl();
        send(9); send(7); send(5); send(3);
        dump_req = 1'b1;
        tick();
        dump_req  = 1'b0;
        out_ready = 1'b1;
        check("t4_rank0", out_data, 9);
        tick();
        check("t4_rank1", 32'(out_rank), 1);
        check("t4_data1", out_data, 7);
        clear     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 100;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        mq.delete();
        check("t4_valid", 32'(out_valid), 0);
        check("t4_last", 32'(out_last), 0);
        check("t4_count", 32'(count), 0);
        check("t4_in_ready", 32'(in_ready), 1);
        dump(1'b0, '0, 0);

        // Scenario 5: asynchronous reset mid-burst.
        send(4); send(6); send(2); send(8);
        dump_req = 1'b1;
        tick();
        dump_req  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        mq.delete();
        check("t5_valid", 32'(out_valid), 0);
        check("t5_count", 32'(count), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_data", out_data, 0);
        check("t5_last", 32'(out_last), 0);
        #3;
        resetn = 1'b1;
        tick();
        check("t5_in_ready", 32'(in_ready), 1);
        check("t5_valid_after", 32'(out_valid), 0);

        // Scenario 6: empty dump ignored, then zero sample with dump.
        dump(1'b0, '0, 0);
        dump(1'b1, '0, 0);

        // Random rounds with ties, full-width values, clears and stalls.
        for (int round = 0; round < 40; round++) begin
            int nsamp;
            if ($urandom_range(0, 3) == 0) clear_tbl();
            nsamp = $urandom_range(0, 7);
            for (int s = 0; s < nsamp; s++) begin
                logic [DW-1:0] x;
                x = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 15)) : DW'($urandom);
                if ($urandom_range(0, 4) == 0) begin
                    tick();
                    check("idle_count", 32'(count), mq.size());
                end else if ($urandom_range(0, 9) == 0) begin
                    clear    = 1'b1;
                    in_valid = 1'b1;
                    in_data  = x;
                    tick();
                    clear    = 1'b0;
                    in_valid = 1'b0;
                    mq.delete();
                    check("clr_sample_count", 32'(count), 0);
                end else begin
                    send(x);
                end
            end
            dump($urandom_range(0, 2) == 0, DW'($urandom), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
